// File: rtl/reg_rename_file_pkg.sv
// Shared widths, constants and operand payload for the rename register file.
package reg_rename_file_pkg;

  localparam int unsigned REG_NUM  = 32;
  localparam int unsigned REG_W    = $clog2(REG_NUM);
  localparam int unsigned ROB_SIZE = 16;
  localparam int unsigned TAG_W    = $clog2(ROB_SIZE);
  localparam int unsigned DATA_W   = 32;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;
  localparam logic READY   = 1'b1;
  localparam logic UNREADY = 1'b0;

  localparam logic [REG_W-1:0]  REG_ZERO  = '0;
  localparam logic [TAG_W-1:0]  TAG_NULL  = '0;
  localparam logic [DATA_W-1:0] DATA_NULL = '0;

  // Dispatch-side operand: either a final value or the producer tag to wait on.
  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } operand_t;

endpackage

// File: rtl/reg_rename_file_src_port.sv
// One source-operand lookup: register read, ROB tag query and reply merge.
module reg_rename_file_src_port
  import reg_rename_file_pkg::*;
(
  input  logic [REG_W-1:0]  src_reg,
  input  logic              src_busy,
  input  logic [TAG_W-1:0]  src_tag,
  input  logic [DATA_W-1:0] src_data,
  input  logic              bypass_hit,
  input  logic [DATA_W-1:0] bypass_data,
  output logic              rob_q_valid,
  output logic [TAG_W-1:0]  rob_q_tag,
  input  logic              rob_q_data_valid,
  input  logic [DATA_W-1:0] rob_q_data,
  output operand_t          op
);

  // Resolve the operand: x0, committed value, bypassed commit, ROB reply, or wait on tag.
  always_comb begin
    rob_q_valid = INVALID;
    rob_q_tag   = TAG_NULL;
    op.ready    = READY;
    op.data     = DATA_NULL;
    op.tag      = TAG_NULL;
    if (src_reg == REG_ZERO) begin
      op.data = DATA_NULL;
    end else if (!src_busy) begin
      op.data = src_data;
    end else if (bypass_hit) begin
      op.data = bypass_data;
    end else begin
      rob_q_valid = VALID;
      rob_q_tag   = src_tag;
      if (rob_q_data_valid) begin
        op.data = rob_q_data;
      end else begin
        op.ready = UNREADY;
        op.tag   = src_tag;
      end
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus rename status table with ROB query/commit ports.
// Optional feature macro: RENAME_COMMIT_BYPASS_EN (a same-cycle matching commit
// satisfies a busy source lookup directly, without a ROB query).
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_reg,
  input  logic [3:0]        alloc_tag,
  input  logic [4:0]        rs1_reg,
  input  logic [4:0]        rs2_reg,
  output logic              rob_q1_valid,
  output logic [3:0]        rob_q1_tag,
  input  logic              rob_q1_data_valid,
  input  logic [31:0]       rob_q1_data,
  output logic              rob_q2_valid,
  output logic [3:0]        rob_q2_tag,
  input  logic              rob_q2_data_valid,
  input  logic [31:0]       rob_q2_data,
  output logic              op1_ready,
  output logic [31:0]       op1_data,
  output logic [3:0]        op1_tag,
  output logic              op2_ready,
  output logic [31:0]       op2_data,
  output logic [3:0]        op2_tag,
  input  logic              commit_valid,
  input  logic [4:0]        commit_reg,
  input  logic [3:0]        commit_tag,
  input  logic [31:0]       commit_data
);

  logic [DATA_W-1:0] data_q [REG_NUM];
  logic              busy_q [REG_NUM];
  logic [TAG_W-1:0]  tag_q  [REG_NUM];

  logic     byp1;
  logic     byp2;
  operand_t op1;
  operand_t op2;

  // State update: commit writes data and retires matching tag; alloc overrides; clear drops all renames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        data_q[i] <= DATA_NULL;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= TAG_NULL;
      end
    end else if (rdy) begin
      if (clear) begin
        for (int unsigned i = 0; i < REG_NUM; i++) begin
          busy_q[i] <= 1'b0;
        end
      end
      if (commit_valid && (commit_reg != REG_ZERO)) begin
        data_q[commit_reg] <= commit_data;
        if (busy_q[commit_reg] && (tag_q[commit_reg] == commit_tag)) begin
          busy_q[commit_reg] <= 1'b0;
        end
      end
      if (alloc_valid && (alloc_reg != REG_ZERO) && !clear) begin
        busy_q[alloc_reg] <= 1'b1;
        tag_q[alloc_reg]  <= alloc_tag;
      end
    end
  end

`ifdef RENAME_COMMIT_BYPASS_EN
  assign byp1 = commit_valid && (commit_reg == rs1_reg) && busy_q[rs1_reg] &&
                (tag_q[rs1_reg] == commit_tag);
  assign byp2 = commit_valid && (commit_reg == rs2_reg) && busy_q[rs2_reg] &&
                (tag_q[rs2_reg] == commit_tag);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  reg_rename_file_src_port u_src1 (
    .src_reg          (rs1_reg),
    .src_busy         (busy_q[rs1_reg]),
    .src_tag          (tag_q[rs1_reg]),
    .src_data         (data_q[rs1_reg]),
    .bypass_hit       (byp1),
    .bypass_data      (commit_data),
    .rob_q_valid      (rob_q1_valid),
    .rob_q_tag        (rob_q1_tag),
    .rob_q_data_valid (rob_q1_data_valid),
    .rob_q_data       (rob_q1_data),
    .op               (op1)
  );

  reg_rename_file_src_port u_src2 (
    .src_reg          (rs2_reg),
    .src_busy         (busy_q[rs2_reg]),
    .src_tag          (tag_q[rs2_reg]),
    .src_data         (data_q[rs2_reg]),
    .bypass_hit       (byp2),
    .bypass_data      (commit_data),
    .rob_q_valid      (rob_q2_valid),
    .rob_q_tag        (rob_q2_tag),
    .rob_q_data_valid (rob_q2_data_valid),
    .rob_q_data       (rob_q2_data),
    .op               (op2)
  );

  assign op1_ready = op1.ready;
  assign op1_data  = op1.data;
  assign op1_tag   = op1.tag;
  assign op2_ready = op2.ready;
  assign op2_data  = op2.data;
  assign op2_tag   = op2.tag;

endmodule
